// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay scheduler: state encoding, default sizes
// and the index-width helper used to size requester indices.
package delay_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COUNT  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Bits needed to index n requesters; never less than one.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) < n) w = k + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward
// from ptr+1 with wrap-around, returned one-hot and as an index.
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        cand     = '0;
        found    = 1'b0;
        // i = NUM_REQ lands back on ptr itself, so the last winner ranks last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick_idx    = cand;
                pick[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_scheduler.sv
// Shared down-counter that runs one requester's programmable delay at a time,
// chosen round-robin, and returns a single-cycle done pulse to the winner.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output state_t                   dbg_state,
    output logic [CNT_W-1:0]         dbg_count
);

    localparam int IDX_W = idx_width(NUM_REQ);

    // Handshake: req[i] is a level held until done[i] pulses; dropping it while
    // granted aborts the delay with no done. gnt[i] marks the owner of the counter.

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   sel, sel_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [CNT_W-1:0]   len_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr[g] = len[g*CNT_W +: CNT_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            sel   <= '0;
            ptr   <= IDX_W'(NUM_REQ - 1);
            count <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        count_nxt = count;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    sel_nxt   = pick_idx;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!req[sel]) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = sel;
                    count_nxt = '0;
                end else begin
                    count_nxt = len_arr[sel];
                    state_nxt = (len_arr[sel] == '0) ? ST_FINISH : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!req[sel]) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = sel;
                    count_nxt = '0;
                end else if (count <= CNT_W'(1)) begin
                    // Holding at 1 (not 0) keeps the counter from ever wrapping.
                    state_nxt = ST_FINISH;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
                ptr_nxt   = sel;
                count_nxt = '0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign gnt       = (state == ST_LOAD || state == ST_COUNT) ? sel_onehot : '0;
    assign done      = (state == ST_FINISH) ? sel_onehot : '0;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign dbg_count = count;

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shared-timer scheduler that lets up to `NUM_REQ` requesters each run a programmable cycle-count delay on one common down-counter. It arbitrates round-robin among pending requests, loads the winner's delay length, counts it out, and returns a one-cycle completion pulse to that requester. It replaces per-FSM private delay counters in the top-level control path, so one 32-bit counter serves all sequencing FSMs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 32: delay counter width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held high until `done` or abort.
- `len`  in  NUM_REQ*CNT_W  per-requester delay length in clk cycles; slice i = `len[i*CNT_W +: CNT_W]`.
- `gnt`  out  NUM_REQ  one-hot grant; high while that requester's delay is loaded or counting.
- `done`  out  NUM_REQ  one-cycle pulse on the granted bit when its delay completes.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, COUNT, FINISH.
- Reset (`rst` low, any time, including mid-delay): state IDLE, counter 0, `gnt`=0, `done`=0, `busy`=0, RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- IDLE: if `req` != 0, select the first set bit searching upward from pointer+1 (wrapping), register `sel`, go to LOAD; otherwise stay.
- LOAD: counter <= `len[sel]`, which is sampled only here; later changes are ignored. `gnt[sel]`=1. If `len[sel]`==0, go to FINISH; else go to COUNT.
- COUNT: counter decrements by 1 per cycle. Go to FINISH when counter==1.
- FINISH: `done[sel]`=1 for exactly this cycle; `gnt`=0; pointer <= `sel`; go to IDLE.
- Abort: if `req[sel]` is low in LOAD or COUNT, go directly to IDLE. No `done` pulse. Pointer <= `sel`. Counter is cleared.
- A requester that keeps `req` high after `done` is re-arbitrated as a fresh request and ranks last behind the other pending requesters.
- The counter never wraps. Decrement occurs only while the counter ≥ 2 in COUNT.
- Requests arriving during a delay wait; there is no queue depth beyond the `req` levels themselves.

## Timing
- All outputs are registered and decoded from the state and `sel` registers; there is no combinational input-to-output path.
- Cycle t (IDLE, `req` sampled) → t+1 LOAD, `gnt` high → t+2..t+1+L COUNT (L cycles) → t+2+L FINISH with `done` pulse → t+3+L IDLE.
- Total request-to-`done` latency = L+2 cycles for L≥1. For L=0 it is 2 cycles (LOAD → FINISH).
- Back-to-back: the earliest next grant is t+4+L, because IDLE costs one cycle between delays.
- `gnt` is high for L+1 cycles when L≥1 and falls in the same cycle that `done` rises.
- Abort seen at cycle k: IDLE at k+1, `gnt` low at k+1.
- Simultaneous requests in IDLE: only the RR winner is granted; the others remain pending.

## Structure
- Package `delay_sched_pkg` holds:
  - state encoding constants (IDLE=0, LOAD=1, COUNT=2, FINISH=3, 2 bits wide);
  - `NUM_REQ` / `CNT_W` defaults;
  - an index-width function (clog2).
- Sub-module `rr_arbiter`: combinational round-robin pick with inputs `req` and pointer, outputs one-hot `pick` and its index. It is instantiated once. The FSM, counter and pointer registers live in `delay_scheduler`.

## Test plan
- Reset, then `req`=0001 with `len[0]`=5 → `gnt`=0001 for 6 cycles, `done`=0001 pulse at 7 cycles after `req` is sampled, `busy` low the following cycle.
- `req`=1011 held together, all `len`=3, each requester dropping `req` after its `done` → grant order 0, 1, 3; each `done` is spaced 6 cycles apart.
- `len[2]`=0, `req`=0100 → `done`=0100 exactly 2 cycles after sampling; the counter never leaves 0.
- `len[1]`=100, `req[1]` dropped on the 10th COUNT cycle → no `done`, `gnt`=0 next cycle, state IDLE; a subsequent `req[0]` is granted normally.
- `rst` pulled low during COUNT with `len`=50 → all outputs 0 immediately (asynchronous); after release, with `req`=0011, requester 0 is granted first.
- `len[0]` changed from 8 to 2 during COUNT → the delay still completes after 8 counts; `len[0]`=2^32-1 sampled once confirms there is no overflow at LOAD.
